// File: rtl/ysyx_25020047_exec_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_25020047_exec_ctrl
// Purpose  : Multi-cycle execution sequencer for the ysyx_25020047 core.
//            Owns the PC, drives the fetch and load request handshakes,
//            steps each instruction through FETCH/DECODE/EXEC/(MEM)/WB,
//            and keeps cycle and retired-instruction counters. An illegal
//            instruction type or a bus timeout parks the sequencer in HALT
//            with a trap code until reset.
// Ports    : clk, rst_n                 - clock, async active-low reset
//            ifu_req/ifu_gnt/ir_we      - instruction fetch handshake
//            inst_type                  - one-hot decoded instruction type
//            lsu_req/lsu_gnt            - load handshake
//            dnpc                       - next PC from writeback
//            pc, rf_wen, pc_wen         - PC and writeback strobes
//            busy, halt, trap_code      - status
//            cycle_cnt, instret         - performance counters
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_25020047_exec_ctrl #(
    parameter logic [31:0] RESET_PC    = 32'h8000_0000,
    parameter int unsigned BUS_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        ifu_req,
    input  logic        ifu_gnt,
    output logic        ir_we,
    input  logic [31:0] inst_type,
    output logic        lsu_req,
    input  logic        lsu_gnt,
    input  logic [31:0] dnpc,
    output logic [31:0] pc,
    output logic        rf_wen,
    output logic        pc_wen,
    output logic        busy,
    output logic        halt,
    output logic [1:0]  trap_code,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;

    localparam logic [1:0] TRAP_NONE    = 2'b00;
    localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
    localparam logic [1:0] TRAP_TIMEOUT = 2'b10;

    // The wait counter holds the number of grant-less cycles already spent.
    // A request that is still ungranted in the cycle where this count is
    // BUS_TIMEOUT-1 has reached the limit; a grant in that cycle still wins.
    localparam logic [7:0] WAIT_LAST = 8'(BUS_TIMEOUT - 1);

    logic [2:0]  state_q,   state_d;
    logic [7:0]  wait_q,    wait_d;
    logic [1:0]  trap_q,    trap_d;
    logic        is_load_q, is_load_d;
    logic [31:0] pc_q;
    logic [31:0] cycle_q;
    logic [31:0] instret_q;

    logic        legal_inst;
    logic        load_inst;

    // One-hot type decode; anything else (zero, multi-hot, unknown codes)
    // is illegal.
    always_comb begin
        legal_inst = 1'b0;
        load_inst  = 1'b0;
        case (inst_type)
            32'h0000_0001,
            32'h0000_0002,
            32'h0000_0008,
            32'h0000_0010: legal_inst = 1'b1;
            32'h0000_0020,
            32'h0000_0040: begin
                legal_inst = 1'b1;
                load_inst  = 1'b1;
            end
            default: begin
                legal_inst = 1'b0;
                load_inst  = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        trap_d    = trap_q;
        is_load_d = is_load_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
                wait_d  = 8'd0;
            end
            S_FETCH: begin
                if (ifu_gnt) begin
                    state_d = S_DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_HALT;
                    trap_d  = TRAP_TIMEOUT;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_DECODE: begin
                // Remember the load decision so EXEC does not depend on
                // inst_type still being stable a cycle later.
                is_load_d = load_inst;
                if (legal_inst) begin
                    state_d = S_EXEC;
                end else begin
                    state_d = S_HALT;
                    trap_d  = TRAP_ILLEGAL;
                end
            end
            S_EXEC: begin
                if (is_load_q) begin
                    state_d = S_MEM;
                    wait_d  = 8'd0;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (lsu_gnt) begin
                    state_d = S_WB;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_HALT;
                    trap_d  = TRAP_TIMEOUT;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_WB: begin
                state_d = S_FETCH;
                wait_d  = 8'd0;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            wait_q    <= 8'd0;
            trap_q    <= TRAP_NONE;
            is_load_q <= 1'b0;
            pc_q      <= RESET_PC;
            cycle_q   <= 32'd0;
            instret_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            trap_q    <= trap_d;
            is_load_q <= is_load_d;
            cycle_q   <= cycle_q + 32'd1;
            if (state_q == S_WB) begin
                pc_q      <= dnpc;
                instret_q <= instret_q + 32'd1;
            end
        end
    end

    // Requests and strobes decode from state alone so that reset drops them
    // the instant rst_n falls; only ir_we looks at the grant.
    assign ifu_req   = (state_q == S_FETCH);
    assign ir_we     = ifu_req & ifu_gnt;
    assign lsu_req   = (state_q == S_MEM);
    assign rf_wen    = (state_q == S_WB);
    assign pc_wen    = (state_q == S_WB);
    assign busy      = (state_q != S_IDLE) && (state_q != S_HALT);
    assign halt      = (state_q == S_HALT);
    assign trap_code = trap_q;
    assign pc        = pc_q;
    assign cycle_cnt = cycle_q;
    assign instret   = instret_q;

endmodule
`default_nettype wire

// File: doc/ysyx_25020047_exec_ctrl.md
# ysyx_25020047_exec_ctrl

Multi-cycle execution sequencer for the ysyx_25020047 core. It owns the PC register, drives the instruction-fetch and load-memory request handshakes, and sequences decode, execute and writeback for the supported instruction set. It generates the register-file write strobe and the PC update from the writeback stage's next-PC value, and it also keeps cycle and retired-instruction counters and halts with a trap code on an illegal instruction or a bus timeout.

## Interface
- RESET_PC, 32'h8000_0000, PC value loaded on reset
- BUS_TIMEOUT, 255, maximum wait cycles for a grant in FETCH or MEM (8-bit counter, legal range 1..255)

- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset, asynchronous and active-low
- ifu_req  out  1  instruction fetch request for address `pc`
- ifu_gnt  in  1  fetch grant; instruction word is valid in the same cycle
- ir_we  out  1  instruction-register load strobe
- inst_type  in  32  one-hot decoded type: 0x1 addi, 0x2 jalr, 0x8 add, 0x10 lui, 0x20 lw, 0x40 lbu
- lsu_req  out  1  load request
- lsu_gnt  in  1  load grant; `memdata` is valid in the same cycle
- dnpc  in  32  next PC from the writeback unit
- pc  out  32  current PC
- rf_wen  out  1  register-file write enable, 1-cycle pulse
- pc_wen  out  1  PC update pulse; `pc` takes `dnpc` on the following edge
- busy  out  1  high in every state except IDLE and HALT
- halt  out  1  high in HALT
- trap_code  out  2  00 none, 01 illegal inst_type, 10 bus timeout
- cycle_cnt  out  32  cycles since reset
- instret  out  32  retired instructions

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT. Reset enters IDLE.
- IDLE lasts one cycle, then goes to FETCH.
- FETCH:
  - `ifu_req` = 1.
  - On `ifu_gnt`: `ir_we` = 1 for that cycle, then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: sample `inst_type`.
  - Exactly one of the six legal codes: go to EXEC.
  - Any other value, including 0 and multi-hot: go to HALT with `trap_code` = 01.
- EXEC lasts one cycle.
  - lw or lbu: go to MEM.
  - Otherwise: go to WB.
- MEM:
  - `lsu_req` = 1.
  - On `lsu_gnt`: go to WB.
  - Otherwise stay in MEM.
- WB:
  - `rf_wen` = 1 and `pc_wen` = 1 for exactly one cycle.
  - `pc` <= `dnpc` and `instret` += 1 on the closing edge.
  - Then go to FETCH.
- HALT:
  - Absorbing; only reset exits it.
  - No requests and no strobes; `pc` and `instret` are frozen.
  - `cycle_cnt` keeps counting.
- Requests are held high until granted. Request address and type never change while a request is pending.
- Wait counter:
  - Cleared on entry to FETCH and to MEM.
  - Increments on each cycle in FETCH or MEM without a grant.
  - If it reaches BUS_TIMEOUT without a grant: go to HALT with `trap_code` = 10.
  - A grant in the same cycle the limit is reached wins; no trap.
- `cycle_cnt` and `instret` are 32-bit and wrap modulo 2^32 with no flag.
- `pc` is not alignment-checked; `dnpc` is taken as-is.

## Timing
- Reset values (applied asynchronously on `rst_n` low):
  - `pc` = RESET_PC
  - state IDLE
  - all strobes and requests 0
  - `busy` 0, `halt` 0, `trap_code` 00
  - `cycle_cnt` 0, `instret` 0
- `rst_n` low mid-operation aborts immediately: outstanding requests drop in the same cycle and no partial writeback occurs.
- All outputs are registered or decoded from state only. There is no combinational path from `ifu_gnt`/`lsu_gnt` to `ifu_req`/`lsu_req`. `ir_we` is the exception: it equals `ifu_req & ifu_gnt`.
- Latency with zero-wait grants:
  - ALU/jalr/lui: 4 cycles per instruction (FETCH, DECODE, EXEC, WB).
  - Loads: 5 cycles per instruction.
- Each wait cycle adds 1 to the instruction's latency.
- The first `ifu_req` is asserted in the second cycle after `rst_n` deasserts.
- `rf_wen` and `pc_wen` are always coincident.
- `instret` increments exactly once per WB.

## Test plan
- Reset with RESET_PC = 0x8000_0000; `ifu_gnt` tied high; `inst_type` = 0x8 and `dnpc` = `pc`+4 throughout → `pc` sequence 0x8000_0000, 0x8000_0004, 0x8000_0008; `rf_wen` every 4th cycle; `instret` = 3 after 12 busy cycles.
- `inst_type` = 0x20 with `lsu_gnt` delayed 3 cycles → `lsu_req` high for 4 cycles; WB occurs in the 8th cycle of the instruction; `rf_wen` is a single pulse.
- `inst_type` = 0x2 with `dnpc` = 0x8000_0100 → `pc` = 0x8000_0100 after WB; the next `ifu_req` presents 0x8000_0100.
- `inst_type` = 0x0, then separately 0x3 → HALT, `trap_code` = 01, `instret` unchanged, no `rf_wen`; `cycle_cnt` keeps incrementing.
- BUS_TIMEOUT = 4 with `ifu_gnt` never asserted → HALT with `trap_code` = 10. A repeat with the grant arriving exactly at the 4th wait cycle → no trap.
- Assert `rst_n` low during MEM with `lsu_req` high → `lsu_req` drops in the same cycle; `pc` = RESET_PC; both counters 0; after release, IDLE then FETCH.
